// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: datapath widths and the ALU
// operation / operand-select encodings used by the decoder.
package exec_pkg;

  localparam int CPU_WIDTH     = 32;
  localparam int EXU_OPT_WIDTH = 4;
  localparam int EXU_SEL_WIDTH = 3;
  localparam int REG_NUM       = 32;
  localparam int REG_AW        = 5;

  typedef logic [CPU_WIDTH-1:0]     word_t;
  typedef logic [EXU_OPT_WIDTH-1:0] opt_t;
  typedef logic [EXU_SEL_WIDTH-1:0] sel_t;
  typedef logic [REG_AW-1:0]        raddr_t;

  localparam opt_t OPT_ADD  = 4'd0;
  localparam opt_t OPT_SUB  = 4'd1;
  localparam opt_t OPT_SLL  = 4'd2;
  localparam opt_t OPT_SLT  = 4'd3;
  localparam opt_t OPT_SLTU = 4'd4;
  localparam opt_t OPT_XOR  = 4'd5;
  localparam opt_t OPT_SRL  = 4'd6;
  localparam opt_t OPT_SRA  = 4'd7;
  localparam opt_t OPT_OR   = 4'd8;
  localparam opt_t OPT_AND  = 4'd9;
  localparam opt_t OPT_BEQ  = 4'd10;
  localparam opt_t OPT_BNE  = 4'd11;
  localparam opt_t OPT_BLT  = 4'd12;
  localparam opt_t OPT_BGE  = 4'd13;
  localparam opt_t OPT_BLTU = 4'd14;
  localparam opt_t OPT_BGEU = 4'd15;

  localparam sel_t SEL_RS1_RS2  = 3'd0;
  localparam sel_t SEL_RS1_IMM  = 3'd1;
  localparam sel_t SEL_PC_IMM   = 3'd2;
  localparam sel_t SEL_PC_4     = 3'd3;
  localparam sel_t SEL_ZERO_IMM = 3'd4;

  function automatic word_t flag_word(input logic f);
    return {{(CPU_WIDTH-1){1'b0}}, f};
  endfunction

endpackage

// File: rtl/exec_regfile_core_if.sv
// Decoder-facing bus of the execute core: register file ports,
// ALU controls and results.
interface exec_regfile_core_if;
  import exec_pkg::*;

  logic   wr_en_Rd;
  raddr_t addr_Rd;
  word_t  data_Rd;
  raddr_t addr_Rs1;
  raddr_t addr_Rs2;
  word_t  data_Rs1;
  word_t  data_Rs2;
  word_t  pc;
  word_t  imm;
  opt_t   exu_opt_code;
  sel_t   exu_sel_code;
  word_t  exu_res;
  logic   zero;

  modport master (
    output wr_en_Rd, addr_Rd, data_Rd,
    output addr_Rs1, addr_Rs2,
    output pc, imm,
    output exu_opt_code, exu_sel_code,
    input  data_Rs1, data_Rs2,
    input  exu_res, zero
  );

  modport slave (
    input  wr_en_Rd, addr_Rd, data_Rd,
    input  addr_Rs1, addr_Rs2,
    input  pc, imm,
    input  exu_opt_code, exu_sel_code,
    output data_Rs1, data_Rs2,
    output exu_res, zero
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational RV32I ALU: operand select, operation mux, zero flag.
// Branch opcodes return 0 when taken so the PCU can use zero directly.
module exec_alu
  import exec_pkg::*;
(
  input  sel_t  sel,
  input  opt_t  opt,
  input  word_t rs1,
  input  word_t rs2,
  input  word_t pc,
  input  word_t imm,
  output word_t res,
  output logic  zero
);

  word_t      op_a;
  word_t      op_b;
  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;
  logic       eq;

  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (sel)
      SEL_RS1_RS2: begin
        op_a = rs1;
        op_b = rs2;
      end
      SEL_RS1_IMM: begin
        op_a = rs1;
        op_b = imm;
      end
      SEL_PC_IMM: begin
        op_a = pc;
        op_b = imm;
      end
      SEL_PC_4: begin
        op_a = pc;
        op_b = word_t'(4);
      end
      SEL_ZERO_IMM: begin
        op_a = '0;
        op_b = imm;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  always_comb begin
    shamt = op_b[4:0];
    lt_s  = $signed(op_a) < $signed(op_b);
    lt_u  = op_a < op_b;
    eq    = op_a == op_b;
  end

  always_comb begin
    res = '0;
    unique case (opt)
      OPT_ADD:  res = op_a + op_b;
      OPT_SUB:  res = op_a - op_b;
      OPT_SLL:  res = op_a << shamt;
      OPT_SLT:  res = flag_word(lt_s);
      OPT_SLTU: res = flag_word(lt_u);
      OPT_XOR:  res = op_a ^ op_b;
      OPT_SRL:  res = op_a >> shamt;
      OPT_SRA:  res = word_t'($signed(op_a) >>> shamt);
      OPT_OR:   res = op_a | op_b;
      OPT_AND:  res = op_a & op_b;
      OPT_BEQ:  res = flag_word(!eq);
      OPT_BNE:  res = flag_word(eq);
      OPT_BLT:  res = flag_word(!lt_s);
      OPT_BGE:  res = flag_word(lt_s);
      OPT_BLTU: res = flag_word(!lt_u);
      OPT_BGEU: res = flag_word(lt_u);
      default:  res = '0;
    endcase
  end

  assign zero = ~|res;

endmodule

// File: rtl/exec_regfile_core.sv
// Execute-stage core: registered reset, 32x32 GPR with two async
// read ports and one sync write port, and the ALU.
module exec_regfile_core
  import exec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 rstn_sync,
  exec_regfile_core_if.slave   bus
);

  logic  rstn_sync_d;
  logic  rstn_sync_q;
  word_t regs_d [REG_NUM];
  word_t regs_q [REG_NUM];

  always_comb begin
    rstn_sync_d = rstn;
  end

  always_ff @(posedge clk) begin
    rstn_sync_q <= rstn_sync_d;
  end

  assign rstn_sync = rstn_sync_q;

  // Delayed reset clears the array and wins over any same-cycle write.
  always_comb begin
    regs_d = regs_q;
    if (rstn_sync_q) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_d[i] = '0;
      end
    end else if (bus.wr_en_Rd && (bus.addr_Rd != '0)) begin
      regs_d[bus.addr_Rd] = bus.data_Rd;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    bus.data_Rs1 = '0;
    bus.data_Rs2 = '0;
    if (bus.addr_Rs1 != '0) begin
      bus.data_Rs1 = regs_q[bus.addr_Rs1];
    end
    if (bus.addr_Rs2 != '0) begin
      bus.data_Rs2 = regs_q[bus.addr_Rs2];
    end
  end

  exec_alu u_alu (
    .sel  (bus.exu_sel_code),
    .opt  (bus.exu_opt_code),
    .rs1  (bus.data_Rs1),
    .rs2  (bus.data_Rs2),
    .pc   (bus.pc),
    .imm  (bus.imm),
    .res  (bus.exu_res),
    .zero (bus.zero)
  );

endmodule

// File: tb/tb_exec_regfile_core.sv
// Self-checking bench for exec_regfile_core: reset and GPR sequences
// plus a table of ALU vectors checked through a scoreboard queue.
module tb_exec_regfile_core;
  import exec_pkg::*;

  typedef struct {
    string name;
    word_t a;
    word_t b;
    word_t pc;
    word_t imm;
    opt_t  opt;
    sel_t  sel;
    word_t res;
    logic  z;
  } vec_t;

  typedef struct {
    string name;
    word_t res;
    logic  z;
  } exp_t;

  logic clk;
  logic rstn;
  logic rstn_sync;

  exec_regfile_core_if bus ();

  exec_regfile_core dut (
    .clk       (clk),
    .rstn      (rstn),
    .rstn_sync (rstn_sync),
    .bus       (bus.slave)
  );

  int   n_checks;
  int   n_fail;
  vec_t vecs [20];
  exp_t sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input raddr_t a, input word_t d);
    edge1();
    bus.wr_en_Rd = 1'b1;
    bus.addr_Rd  = a;
    bus.data_Rd  = d;
    edge1();
    bus.wr_en_Rd = 1'b0;
  endtask

  function automatic vec_t mk(
    input string n, input word_t a, input word_t b,
    input word_t p, input word_t i, input opt_t o,
    input sel_t s, input word_t r, input logic z);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.pc = p; v.imm = i;
    v.opt = o; v.sel = s; v.res = r; v.z = z;
    return v;
  endfunction

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = mk("add_wrap", 32'hFFFFFFFF, 32'h1, 0, 0,
                  OPT_ADD, SEL_RS1_RS2, 32'h0, 1'b1);
    vecs[1]  = mk("sub", 32'd5, 32'd7, 0, 0,
                  OPT_SUB, SEL_RS1_RS2, 32'hFFFFFFFE, 1'b0);
    vecs[2]  = mk("slt", 32'hFFFFFFFF, 32'h1, 0, 0,
                  OPT_SLT, SEL_RS1_RS2, 32'h1, 1'b0);
    vecs[3]  = mk("sltu", 32'hFFFFFFFF, 32'h1, 0, 0,
                  OPT_SLTU, SEL_RS1_RS2, 32'h0, 1'b1);
    vecs[4]  = mk("sra", 32'h80000000, 32'h24, 0, 0,
                  OPT_SRA, SEL_RS1_RS2, 32'hF8000000, 1'b0);
    vecs[5]  = mk("srl", 32'h80000000, 32'h24, 0, 0,
                  OPT_SRL, SEL_RS1_RS2, 32'h08000000, 1'b0);
    vecs[6]  = mk("sll", 32'h1, 32'd31, 0, 0,
                  OPT_SLL, SEL_RS1_RS2, 32'h80000000, 1'b0);
    vecs[7]  = mk("pc_4", 0, 0, 32'h80000000, 0,
                  OPT_ADD, SEL_PC_4, 32'h80000004, 1'b0);
    vecs[8]  = mk("pc_imm", 0, 0, 32'h80000000, 32'hFFFFFFF0,
                  OPT_ADD, SEL_PC_IMM, 32'h7FFFFFF0, 1'b0);
    vecs[9]  = mk("zero_imm", 32'h9, 0, 32'h44, 32'h12345000,
                  OPT_ADD, SEL_ZERO_IMM, 32'h12345000, 1'b0);
    vecs[10] = mk("beq", 32'd7, 32'd7, 0, 0,
                  OPT_BEQ, SEL_RS1_RS2, 32'h0, 1'b1);
    vecs[11] = mk("bne", 32'd7, 32'd7, 0, 0,
                  OPT_BNE, SEL_RS1_RS2, 32'h1, 1'b0);
    vecs[12] = mk("blt", 32'hFFFFFFFF, 32'h1, 0, 0,
                  OPT_BLT, SEL_RS1_RS2, 32'h0, 1'b1);
    vecs[13] = mk("bltu", 32'hFFFFFFFF, 32'h1, 0, 0,
                  OPT_BLTU, SEL_RS1_RS2, 32'h1, 1'b0);
    vecs[14] = mk("bgeu", 32'hFFFFFFFF, 32'h1, 0, 0,
                  OPT_BGEU, SEL_RS1_RS2, 32'h0, 1'b1);
    vecs[15] = mk("bge", 32'hFFFFFFFF, 32'h1, 0, 0,
                  OPT_BGE, SEL_RS1_RS2, 32'h1, 1'b0);
    vecs[16] = mk("xor", 32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0,
                  OPT_XOR, SEL_RS1_RS2, 32'hAAAAAAAA, 1'b0);
    vecs[17] = mk("and", 32'hA5A5A5A5, 32'h0F0F0F0F, 0, 0,
                  OPT_AND, SEL_RS1_RS2, 32'h05050505, 1'b0);
    vecs[18] = mk("rs1_imm", 32'd10, 32'd3, 0, 32'hFFFFFFFB,
                  OPT_ADD, SEL_RS1_IMM, 32'h5, 1'b0);
    vecs[19] = mk("sel_rsvd", 32'd3, 32'd8, 32'h40, 32'd9,
                  OPT_OR, 3'd5, 32'h0, 1'b1);

    bus.wr_en_Rd     = 1'b0;
    bus.addr_Rd      = '0;
    bus.data_Rd      = '0;
    bus.addr_Rs1     = '0;
    bus.addr_Rs2     = '0;
    bus.pc           = '0;
    bus.imm          = '0;
    bus.exu_opt_code = OPT_ADD;
    bus.exu_sel_code = SEL_RS1_RS2;

    rstn = 1'b1;
    repeat (3) edge1();
    rstn = 1'b0;
    edge1();
    chk("rst_sync_low", word_t'(rstn_sync), 32'h0);
    bus.addr_Rs1 = 5'd5;
    bus.addr_Rs2 = 5'd31;
    #2;
    chk("rst_x5", bus.data_Rs1, 32'h0);
    chk("rst_x31", bus.data_Rs2, 32'h0);

    wr(5'd5, 32'h55555555);
    wr(5'd6, 32'h66666666);
    #2;
    chk("pre_rst_x5", bus.data_Rs1, 32'h55555555);
    rstn = 1'b1;
    #2;
    chk("rst_sync_lag", word_t'(rstn_sync), 32'h0);
    edge1();
    chk("rst_sync_high", word_t'(rstn_sync), 32'h1);
    chk("x5_before_clr", bus.data_Rs1, 32'h55555555);
    bus.wr_en_Rd = 1'b1;
    bus.addr_Rd  = 5'd6;
    bus.data_Rd  = 32'hAAAAAAAA;
    bus.addr_Rs2 = 5'd6;
    edge1();
    bus.wr_en_Rd = 1'b0;
    chk("x5_cleared", bus.data_Rs1, 32'h0);
    chk("x6_wr_dropped", bus.data_Rs2, 32'h0);
    rstn = 1'b0;
    #2;
    chk("rst_sync_hold", word_t'(rstn_sync), 32'h1);
    edge1();
    chk("rst_sync_release", word_t'(rstn_sync), 32'h0);

    wr(5'd3, 32'hDEADBEEF);
    bus.addr_Rs1 = 5'd3;
    bus.addr_Rs2 = 5'd3;
    #2;
    chk("x3_rs1", bus.data_Rs1, 32'hDEADBEEF);
    chk("x3_rs2", bus.data_Rs2, 32'hDEADBEEF);
    wr(5'd0, 32'h00001234);
    bus.addr_Rs1 = 5'd0;
    bus.addr_Rs2 = 5'd0;
    #2;
    chk("x0_rs1", bus.data_Rs1, 32'h0);
    chk("x0_rs2", bus.data_Rs2, 32'h0);
    edge1();
    bus.addr_Rs1 = 5'd3;
    bus.wr_en_Rd = 1'b1;
    bus.addr_Rd  = 5'd3;
    bus.data_Rd  = 32'h11111111;
    #2;
    chk("no_bypass", bus.data_Rs1, 32'hDEADBEEF);
    edge1();
    bus.wr_en_Rd = 1'b0;
    chk("x3_updated", bus.data_Rs1, 32'h11111111);

    for (int i = 0; i < 20; i++) begin
      wr(5'd1, vecs[i].a);
      wr(5'd2, vecs[i].b);
      bus.addr_Rs1     = 5'd1;
      bus.addr_Rs2     = 5'd2;
      bus.pc           = vecs[i].pc;
      bus.imm          = vecs[i].imm;
      bus.exu_opt_code = vecs[i].opt;
      bus.exu_sel_code = vecs[i].sel;
      e.name = vecs[i].name;
      e.res  = vecs[i].res;
      e.z    = vecs[i].z;
      sb.push_back(e);
      #3;
      chk({vecs[i].name, "_rs2"}, bus.data_Rs2, vecs[i].b);
      e = sb.pop_front();
      chk({e.name, "_res"}, bus.exu_res, e.res);
      chk({e.name, "_zero"}, word_t'(bus.zero), word_t'(e.z));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
